// File: rtl/tt_um_jleugeri_ttt_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tt_um_jleugeri_ttt : shared stage encoding, token pair, saturating add |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package tt_um_jleugeri_ttt;

  localparam int TOKEN_BITS = 4;

  typedef enum logic [2:0] {
    STAGE_RESET     = 3'd0,
    STAGE_INPUT     = 3'd1,
    STAGE_RECURRENT = 3'd2,
    STAGE_UPDATE    = 3'd3,
    STAGE_OUTPUT    = 3'd4
  } stage_t;

  typedef struct packed {
    logic signed [TOKEN_BITS-1:0] good;
    logic signed [TOKEN_BITS-1:0] bad;
  } token_pair_t;

  // Operands arrive sign-extended to 32 bits; result is clamped to a signed width-bit range.
  function automatic logic signed [31:0] sat_add(input int width,
                                                  input logic signed [31:0] a,
                                                  input logic signed [31:0] b);
    longint sum;
    longint hi;
    longint lo;
    sum = longint'(a) + longint'(b);
    hi  = (longint'(1) << (width - 1)) - 1;
    lo  = -hi - 1;
    if (sum > hi)      sum = hi;
    else if (sum < lo) sum = lo;
    return 32'(sum);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tt_um_jleugeri_ttt_token_cache.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tt_um_jleugeri_ttt_token_cache : per-processor saturating token cache |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tt_um_jleugeri_ttt_token_cache
  import tt_um_jleugeri_ttt::*;
#(
  parameter int NUM_PROCESSORS = 10,
  parameter int PID_BITS       = $clog2(NUM_PROCESSORS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear_i,
  input  logic                add_valid_i,
  input  logic [PID_BITS-1:0] add_addr_i,
  input  token_pair_t         add_pair_i,
  input  logic [PID_BITS-1:0] rd_addr_i,
  output token_pair_t         rd_pair_o
);

  localparam logic [PID_BITS:0] c_NUM_PROC = (PID_BITS+1)'(NUM_PROCESSORS);

  token_pair_t w_entries [NUM_PROCESSORS];
  token_pair_t w_cur;
  token_pair_t w_sum;
  logic        w_add_in_range;
  logic        w_rd_in_range;

  assign w_add_in_range = ({1'b0, add_addr_i} < c_NUM_PROC);
  assign w_rd_in_range  = ({1'b0, rd_addr_i} < c_NUM_PROC);

  assign w_cur      = w_add_in_range ? w_entries[add_addr_i] : '0;
  assign w_sum.good = TOKEN_BITS'(sat_add(TOKEN_BITS, 32'(w_cur.good), 32'(add_pair_i.good)));
  assign w_sum.bad  = TOKEN_BITS'(sat_add(TOKEN_BITS, 32'(w_cur.bad),  32'(add_pair_i.bad)));

  assign rd_pair_o = w_rd_in_range ? w_entries[rd_addr_i] : '0;

  // Out-of-range addresses match no entry, so those adds vanish silently.
  for (genvar i = 0; i < NUM_PROCESSORS; i++) begin : g_entry
    token_pair_t entry_q;
    logic        w_hit;

    assign w_hit        = add_valid_i && w_add_in_range && (add_addr_i == PID_BITS'(i));
    assign w_entries[i] = entry_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)          entry_q <= '0;
      else if (clear_i) entry_q <= '0;
      else if (w_hit)   entry_q <= w_sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tt_um_jleugeri_ttt_stage_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tt_um_jleugeri_ttt_stage_sequencer : RESET/INPUT/RECURRENT/UPDATE/    |
// | OUTPUT stage controller owning the new-token cache.        Rev 1.0    |
// +-----------------------------------------------------------------------+
module tt_um_jleugeri_ttt_stage_sequencer
  import tt_um_jleugeri_ttt::*;
#(
  parameter  int NUM_PROCESSORS  = 10,
  parameter  int NEW_TOKENS_BITS = TOKEN_BITS,
  localparam int PID_BITS        = $clog2(NUM_PROCESSORS)
) (
  input  logic                              clock_fast,
  input  logic                              reset,
  input  logic                              hold,
  output logic                              done,
  output stage_t                            stage,
  input  logic                              ext_valid,
  output logic                              ext_ready,
  input  logic                              ext_last,
  input  logic [PID_BITS-1:0]               ext_addr,
  input  logic signed [NEW_TOKENS_BITS-1:0] ext_good,
  input  logic signed [NEW_TOKENS_BITS-1:0] ext_bad,
  output logic                              net_start,
  input  logic                              net_valid_out,
  input  logic [PID_BITS-1:0]               net_target_id,
  input  logic signed [NEW_TOKENS_BITS-1:0] net_good,
  input  logic signed [NEW_TOKENS_BITS-1:0] net_bad,
  input  logic                              net_done,
  output logic                              processor_reset,
  output logic                              proc_valid,
  output logic [PID_BITS-1:0]               processor_id,
  output logic signed [NEW_TOKENS_BITS-1:0] new_good_tokens,
  output logic signed [NEW_TOKENS_BITS-1:0] new_bad_tokens,
  output logic                              out_valid,
  input  logic                              out_ready
);

  localparam logic [PID_BITS-1:0] c_LAST_IDX = PID_BITS'(NUM_PROCESSORS - 1);

  stage_t              stage_q, stage_d, w_next_stage;
  logic                done_q, done_d;
  logic                entry_q, entry_d;
  logic [PID_BITS-1:0] idx_q, idx_d;

  logic                w_ext_fire;
  logic                w_clear;
  logic                w_add_valid;
  logic [PID_BITS-1:0] w_add_addr;
  token_pair_t         w_add_pair;
  token_pair_t         w_rd_pair;

  // entry_q marks the first cycle of every stage.
  assign ext_ready       = (stage_q == STAGE_INPUT) && !entry_q && !done_q;
  assign net_start       = (stage_q == STAGE_RECURRENT) && entry_q;
  assign proc_valid      = (stage_q == STAGE_UPDATE) && !done_q;
  assign out_valid       = (stage_q == STAGE_OUTPUT) && !done_q;
  assign processor_reset = (stage_q == STAGE_RESET);
  assign processor_id    = (proc_valid || out_valid) ? idx_q : '0;
  assign new_good_tokens = proc_valid ? NEW_TOKENS_BITS'(w_rd_pair.good) : '0;
  assign new_bad_tokens  = proc_valid ? NEW_TOKENS_BITS'(w_rd_pair.bad)  : '0;
  assign done            = done_q;
  assign stage           = stage_q;

  assign w_ext_fire = ext_valid && ext_ready;
  assign w_clear    = (stage_q == STAGE_INPUT) && entry_q;

  always_comb begin
    w_add_valid     = 1'b0;
    w_add_addr      = ext_addr;
    w_add_pair.good = TOKEN_BITS'(ext_good);
    w_add_pair.bad  = TOKEN_BITS'(ext_bad);
    if (stage_q == STAGE_INPUT) begin
      w_add_valid = w_ext_fire;
    end else if (stage_q == STAGE_RECURRENT) begin
      w_add_valid     = net_valid_out;
      w_add_addr      = net_target_id;
      w_add_pair.good = TOKEN_BITS'(net_good);
      w_add_pair.bad  = TOKEN_BITS'(net_bad);
    end
  end

  tt_um_jleugeri_ttt_token_cache #(
    .NUM_PROCESSORS(NUM_PROCESSORS),
    .PID_BITS      (PID_BITS)
  ) u_cache (
    .clk        (clock_fast),
    .rst        (reset),
    .clear_i    (w_clear),
    .add_valid_i(w_add_valid),
    .add_addr_i (w_add_addr),
    .add_pair_i (w_add_pair),
    .rd_addr_i  (idx_q),
    .rd_pair_o  (w_rd_pair)
  );

  always_comb begin
    case (stage_q)
      STAGE_RESET:     w_next_stage = STAGE_INPUT;
      STAGE_INPUT:     w_next_stage = STAGE_RECURRENT;
      STAGE_RECURRENT: w_next_stage = STAGE_UPDATE;
      STAGE_UPDATE:    w_next_stage = STAGE_OUTPUT;
      STAGE_OUTPUT:    w_next_stage = STAGE_INPUT;
      default:         w_next_stage = STAGE_RESET;
    endcase
  end

  always_comb begin
    stage_d = stage_q;
    done_d  = done_q;
    idx_d   = idx_q;
    entry_d = 1'b0;
    case (stage_q)
      STAGE_RESET:     done_d = 1'b1;
      STAGE_INPUT:     if (w_ext_fire && ext_last) done_d = 1'b1;
      STAGE_RECURRENT: if (net_done) done_d = 1'b1;
      STAGE_UPDATE: begin
        if (!done_q) begin
          if (idx_q == c_LAST_IDX) done_d = 1'b1;
          else                     idx_d  = idx_q + 1'b1;
        end
      end
      STAGE_OUTPUT: begin
        if (out_valid && out_ready) begin
          if (idx_q == c_LAST_IDX) done_d = 1'b1;
          else                     idx_d  = idx_q + 1'b1;
        end
      end
      default: ;
    endcase
    // hold only gates the hand-off; work inside a stage never waits on it.
    if (done_q && !hold) begin
      stage_d = w_next_stage;
      done_d  = 1'b0;
      idx_d   = '0;
      entry_d = 1'b1;
    end
  end

  always_ff @(posedge clock_fast or posedge reset) begin
    if (reset) begin
      stage_q <= STAGE_RESET;
      done_q  <= 1'b0;
      entry_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      stage_q <= stage_d;
      done_q  <= done_d;
      entry_q <= entry_d;
      idx_q   <= idx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tt_um_jleugeri_ttt_stage_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_tt_um_jleugeri_ttt_stage_sequencer : directed + random stage walk  |
// | against an array-based token model.                        Rev 1.0    |
// +-----------------------------------------------------------------------+
module tb_tt_um_jleugeri_ttt_stage_sequencer;
  import tt_um_jleugeri_ttt::*;

  localparam int NP  = 10;
  localparam int NTB = 4;
  localparam int PB  = 4;

  logic                  clock_fast = 1'b0;
  logic                  reset, hold;
  logic                  done;
  stage_t                stage;
  logic                  ext_valid, ext_ready, ext_last;
  logic [PB-1:0]         ext_addr;
  logic signed [NTB-1:0] ext_good, ext_bad;
  logic                  net_start, net_valid_out, net_done;
  logic [PB-1:0]         net_target_id;
  logic signed [NTB-1:0] net_good, net_bad;
  logic                  processor_reset, proc_valid;
  logic [PB-1:0]         processor_id;
  logic signed [NTB-1:0] new_good_tokens, new_bad_tokens;
  logic                  out_valid, out_ready;

  always #5 clock_fast = ~clock_fast;

  tt_um_jleugeri_ttt_stage_sequencer #(.NUM_PROCESSORS(NP), .NEW_TOKENS_BITS(NTB)) dut (
    .clock_fast(clock_fast), .reset(reset), .hold(hold), .done(done), .stage(stage),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_last(ext_last), .ext_addr(ext_addr),
    .ext_good(ext_good), .ext_bad(ext_bad), .net_start(net_start),
    .net_valid_out(net_valid_out), .net_target_id(net_target_id), .net_good(net_good),
    .net_bad(net_bad), .net_done(net_done), .processor_reset(processor_reset),
    .proc_valid(proc_valid), .processor_id(processor_id), .new_good_tokens(new_good_tokens),
    .new_bad_tokens(new_bad_tokens), .out_valid(out_valid), .out_ready(out_ready)
  );

  typedef struct {
    int addr;
    int good;
    int bad;
  } ent_t;

  int   checks = 0;
  int   errors = 0;
  int   mg [NP];
  int   mb [NP];
  ent_t ext_q[$];
  ent_t net_q[$];

  function automatic int sat(input int a, input int b);
    int s;
    s = a + b;
    if (s > (1 << (NTB - 1)) - 1) s = (1 << (NTB - 1)) - 1;
    if (s < -(1 << (NTB - 1)))    s = -(1 << (NTB - 1));
    return s;
  endfunction

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_fast);
    #1;
  endtask

  function automatic ent_t rnd_ent(input int max_addr);
    ent_t e;
    e.addr = int'($urandom_range(0, max_addr));
    e.good = int'($urandom_range(0, 15)) - 8;
    e.bad  = int'($urandom_range(0, 15)) - 8;
    return e;
  endfunction

  // Entered on the first INPUT cycle; leaves on the first RECURRENT cycle.
  task automatic run_input(input int hold_after);
    ent_t e;
    int   n;
    check("input_stage", stage, STAGE_INPUT);
    check("input_entry_ready", ext_ready, 0);
    for (int i = 0; i < NP; i++) begin mg[i] = 0; mb[i] = 0; end
    for (int k = 0; k < ext_q.size(); k++) begin
      e = ext_q[k];
      hold = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin ext_valid = 1'b0; tick(); end
      ext_valid = 1'b1;
      ext_addr  = e.addr[PB-1:0];
      ext_good  = e.good[NTB-1:0];
      ext_bad   = e.bad[NTB-1:0];
      ext_last  = (k == ext_q.size() - 1);
      n = 0;
      while (!ext_ready && n < 20) begin tick(); n++; end
      if (!ext_ready) check("ext_ready_timeout", ext_ready, 1);
      tick();
      if (e.addr < NP) begin
        mg[e.addr] = sat(mg[e.addr], e.good);
        mb[e.addr] = sat(mb[e.addr], e.bad);
      end
    end
    ext_valid = 1'b0;
    ext_last  = 1'b0;
    check("input_done", done, 1);
    check("input_ready_after_last", ext_ready, 0);
    if (hold_after != 0) begin
      hold = 1'b1;
      tick();
      check("input_held_stage", stage, STAGE_INPUT);
      check("input_held_ready", ext_ready, 0);
    end
    hold = 1'b0;
    tick();
    check("recurrent_stage", stage, STAGE_RECURRENT);
  endtask

  task automatic run_recurrent();
    ent_t e;
    check("net_start_first", net_start, 1);
    ext_valid = 1'b1; ext_addr = '0; ext_good = 4'sd7; ext_bad = 4'sd7;
    tick();
    check("net_start_pulse", net_start, 0);
    check("ext_ready_outside_input", ext_ready, 0);
    for (int k = 0; k < net_q.size(); k++) begin
      e = net_q[k];
      net_valid_out = 1'b1;
      net_target_id = e.addr[PB-1:0];
      net_good      = e.good[NTB-1:0];
      net_bad       = e.bad[NTB-1:0];
      net_done      = (k == net_q.size() - 1);
      tick();
      if (e.addr < NP) begin
        mg[e.addr] = sat(mg[e.addr], e.good);
        mb[e.addr] = sat(mb[e.addr], e.bad);
      end
    end
    if (net_q.size() == 0) begin net_done = 1'b1; tick(); end
    net_valid_out = 1'b0;
    net_done      = 1'b0;
    ext_valid     = 1'b0;
    check("recurrent_done", done, 1);
    tick();
    check("update_stage", stage, STAGE_UPDATE);
  endtask

  task automatic run_update(input int hold_cycles);
    hold = (hold_cycles > 0);
    for (int i = 0; i < NP; i++) begin
      check("update_valid", proc_valid, 1);
      check("update_id", processor_id, i);
      check("update_good", new_good_tokens, mg[i]);
      check("update_bad", new_bad_tokens, mb[i]);
      tick();
    end
    check("update_done", done, 1);
    check("update_valid_off", proc_valid, 0);
    for (int h = 0; h < hold_cycles; h++) begin
      check("update_held_done", done, 1);
      check("update_held_stage", stage, STAGE_UPDATE);
      if (h < hold_cycles - 1) tick();
    end
    hold = 1'b0;
    tick();
    check("output_stage", stage, STAGE_OUTPUT);
  endtask

  task automatic run_output(input int random_ready);
    int e = 0;
    int n = 0;
    while (e < NP && n < 200) begin
      check("output_valid", out_valid, 1);
      check("output_id", processor_id, e);
      out_ready = (random_ready != 0) ? 1'($urandom_range(0, 1)) : ((n % 2) == 0);
      tick();
      n++;
      if (out_ready) e++;
    end
    out_ready = 1'b0;
    check("output_count", e, NP);
    check("output_done", done, 1);
    check("output_valid_off", out_valid, 0);
    tick();
    check("back_to_input", stage, STAGE_INPUT);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; hold = 1'b0;
    ext_valid = 1'b0; ext_last = 1'b0; ext_addr = '0; ext_good = '0; ext_bad = '0;
    net_valid_out = 1'b0; net_done = 1'b0; net_target_id = '0; net_good = '0; net_bad = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    check("reset_stage", stage, STAGE_RESET);
    check("reset_proc_reset", processor_reset, 1);
    check("reset_done", done, 0);
    check("reset_proc_valid", proc_valid, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_ext_ready", ext_ready, 0);
    check("reset_net_start", net_start, 0);
    reset = 1'b0;
    tick();
    check("release_done", done, 1);
    check("release_stage", stage, STAGE_RESET);
    tick();
    check("first_input_proc_reset", processor_reset, 0);
    check("first_input_done", done, 0);

    // Directed pass: saturating ext accumulation, net_done-coincident entry, held UPDATE.
    ext_q.delete(); net_q.delete();
    ext_q.push_back('{2, 3, -1});
    ext_q.push_back('{2, 6, 0});
    net_q.push_back('{5, 1, 1});
    net_q.push_back('{5, -8, 0});
    run_input(0);
    check("model_p2_good", mg[2], 7);
    check("model_p5_good_pending", mg[5], 0);
    run_recurrent();
    check("model_p5_good", mg[5], -7);
    run_update(5);
    run_output(0);

    for (int r = 0; r < 3; r++) begin
      ext_q.delete(); net_q.delete();
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) ext_q.push_back(rnd_ent(15));
      for (int k = 0; k < int'($urandom_range(0, 5)); k++) net_q.push_back(rnd_ent(15));
      run_input(int'($urandom_range(0, 1)));
      run_recurrent();
      run_update(int'($urandom_range(0, 3)));
      run_output(1);
    end

    // Abort mid-UPDATE, then confirm an out-of-range address leaves the cache untouched.
    ext_q.delete(); net_q.delete();
    ext_q.push_back('{4, 5, -5});
    net_q.push_back('{6, 3, 3});
    run_input(0);
    run_recurrent();
    for (int i = 0; i <= 4; i++) begin
      check("abort_update_id", processor_id, i);
      if (i < 4) tick();
    end
    reset = 1'b1;
    #1;
    check("abort_stage", stage, STAGE_RESET);
    check("abort_proc_valid", proc_valid, 0);
    check("abort_proc_reset", processor_reset, 1);
    check("abort_done", done, 0);
    tick();
    reset = 1'b0;
    tick();
    check("abort_release_done", done, 1);
    tick();
    ext_q.delete(); net_q.delete();
    ext_q.push_back('{12, 7, 7});
    ext_q.push_back('{1, 2, -3});
    ext_q.push_back('{12, -8, -8});
    run_input(0);
    run_recurrent();
    run_update(0);
    run_output(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
